// File: rtl/count_uart_tx_if.sv
// Byte handshake between the counter stage and the UART serialiser.
// The counter side drives data/valid; the UART side answers with ready.
interface count_uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter for counter samples.
// Takes one byte per frame over valid/ready and drops anything offered while a
// frame is on the line. tx comes straight from a flop, so the pin never glitches.
module count_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  count_uart_tx_if.slave in_if,
  output logic           tx,
  output logic           busy
);

  // An out-of-range bit period is a build error, not a silent misbehaviour.
  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_param
      $error("count_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
  endgenerate

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_reg;
  logic             tx_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             baud_end;

  // Last cycle of the current serial bit.
  assign baud_end = (baud_cnt_reg == CNT_MAX);

  // Frame sequencer: the next line level is registered together with each state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tx_reg       <= 1'b1;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (in_if.in_valid) begin
            shift_reg    <= in_if.in_data;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= 1'b0;
            state_reg    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            tx_reg       <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {1'b0, shift_reg[7:1]};
            bit_idx_reg  <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              // shift_reg[1] is the bit that lands in position 0 after this shift.
              tx_reg <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Ready depends on state alone, so upstream never sees a path from its own valid.
  assign in_if.in_ready = (state_reg == IDLE);
  assign busy           = (state_reg != IDLE);
  assign tx             = tx_reg;

endmodule
